// File: rtl/add_pkg.sv
// Shared constants for the chunked serial adder: default geometry, FSM state codes
// and the slice-counter width helper.
package add_pkg;

  localparam int unsigned ADD_WIDTH = 32;
  localparam int unsigned ADD_CHUNK = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Slice counter needs at least one bit even when the add completes in a single slice.
  function automatic int unsigned cnt_width(input int unsigned slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit combinational adder slice; also reports the carry into its top bit so
// the caller can derive signed overflow on the most significant slice.
module add_chunk import add_pkg::*; #(
  parameter int unsigned CHUNK = ADD_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum_c,
  output logic             cout_c,
  output logic             cmsb_c
);

  logic [CHUNK:0] total;

  always_comb begin
    total  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum_c  = total[CHUNK-1:0];
    cout_c = total[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    cmsb_c = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/add_serial.sv
// Serial add/subtract: one CHUNK-bit slice per clock through a shared add_chunk,
// with a valid/ready handshake on both sides.
module add_serial import add_pkg::*; #(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned CHUNK = ADD_CHUNK
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SLICES = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(SLICES);
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  if ((WIDTH % CHUNK) != 0 || SLICES == 0) begin : g_bad_geometry
    $error("add_serial: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    k_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] sum_c;
  logic             cout_c;
  logic             cmsb_c;

  // Operands shift right one slice per cycle, so the adder always sees bits [CHUNK-1:0].
  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a      (a_q[CHUNK-1:0]),
    .b      (b_q[CHUNK-1:0]),
    .cin    (carry_q),
    .sum_c  (sum_c),
    .cout_c (cout_c),
    .cmsb_c (cmsb_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = BUSY;
      BUSY:    if (k_q == LAST)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            k_q     <= '0;
          end
        end
        BUSY: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          // New slice enters at the top; after SLICES cycles it has reached its final place.
          s_q     <= WIDTH'({sum_c, s_q} >> CHUNK);
          carry_q <= cout_c;
          k_q     <= k_q + CW'(1);
          if (k_q == LAST) begin
            cout_q <= cout_c;
            ovf_q  <= cout_c ^ cmsb_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
